// File: rtl/td4x_core.sv
// td4x_core: parametrised TD4-style accumulator core.
//
// Fetches one instruction word per FETCH over a req/ack handshake, executes
// it in a single EXEC cycle, and returns to FETCH. A HALT opcode parks the
// core in HALT until reset.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   imem_addr        fetch address (always the PC)
//   imem_req         fetch request, high while in FETCH and not in reset
//   imem_ack         memory answer; imem_data is valid in the same cycle
//   imem_data        instruction word {opcode[3:0], imm[DATA_W-1:0]}
//   in_port          input port, read combinationally during EXEC
//   out_port         registered output port
//   out_strobe       one-cycle pulse in the cycle after out_port is written
//   halted           high while in HALT
//   dbg_state_o      FSM state (0 FETCH, 1 EXEC, 2 HALT)
//   dbg_a_o/_b_o     A and B registers
//   dbg_carry_o      carry flag
//   dbg_ir_o         instruction register
//
// Fetch handshake: imem_req is held high with a stable imem_addr for as long
// as the core waits in FETCH. A transfer happens on every rising edge where
// imem_req and imem_ack are both high; imem_ack in any other cycle is ignored.

module td4x_core #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic [DATA_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic              imem_ack,
    input  logic [DATA_W+3:0] imem_data,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic              out_strobe,
    output logic              halted,
    output logic [1:0]        dbg_state_o,
    output logic [DATA_W-1:0] dbg_a_o,
    output logic [DATA_W-1:0] dbg_b_o,
    output logic              dbg_carry_o,
    output logic [DATA_W+3:0] dbg_ir_o
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD_A   = 4'b0000;
    localparam logic [3:0] OP_MOV_AB  = 4'b0001;
    localparam logic [3:0] OP_IN_A    = 4'b0010;
    localparam logic [3:0] OP_MOV_AI  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA  = 4'b0100;
    localparam logic [3:0] OP_ADD_B   = 4'b0101;
    localparam logic [3:0] OP_IN_B    = 4'b0110;
    localparam logic [3:0] OP_MOV_BI  = 4'b0111;
    localparam logic [3:0] OP_OUT_B   = 4'b1001;
    localparam logic [3:0] OP_OUT_I   = 4'b1011;
    localparam logic [3:0] OP_HALT    = 4'b1100;
    localparam logic [3:0] OP_JNC     = 4'b1110;
    localparam logic [3:0] OP_JMP     = 4'b1111;

    localparam logic [DATA_W-1:0] PC_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                carry_q, carry_d;
    logic [DATA_W+3:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   out_q, out_d;
    logic                strobe_q, strobe_d;

    logic [3:0]          opcode;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   src;
    logic [DATA_W:0]     sum;
    logic                wr_a, wr_b, wr_out, wr_carry, jump;

    assign opcode = ir_q[DATA_W+3:DATA_W];
    assign imm    = ir_q[DATA_W-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: if (imem_ack) state_d = ST_EXEC;
            ST_EXEC:  state_d = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // reset gates imem_req directly so the memory never sees a request in a
    // cycle whose edge is going to discard it.
    always_comb begin
        imem_req    = (state_q == ST_FETCH) && !reset;
        halted      = (state_q == ST_HALT);
        dbg_state_o = state_q;
    end

    // ---------------- Decode ----------------
    // Every ALU-class opcode computes src + imm; the opcode only picks src and
    // the destination. NOP and HALT are the only opcodes that keep carry.
    always_comb begin
        src      = '0;
        wr_a     = 1'b0;
        wr_b     = 1'b0;
        wr_out   = 1'b0;
        wr_carry = 1'b1;
        jump     = 1'b0;
        case (opcode)
            OP_ADD_A:  begin src = a_q;     wr_a = 1'b1;   end
            OP_ADD_B:  begin src = b_q;     wr_b = 1'b1;   end
            OP_MOV_AI: begin                wr_a = 1'b1;   end
            OP_MOV_BI: begin                wr_b = 1'b1;   end
            OP_MOV_AB: begin src = b_q;     wr_a = 1'b1;   end
            OP_MOV_BA: begin src = a_q;     wr_b = 1'b1;   end
            OP_IN_A:   begin src = in_port; wr_a = 1'b1;   end
            OP_IN_B:   begin src = in_port; wr_b = 1'b1;   end
            OP_OUT_B:  begin src = b_q;     wr_out = 1'b1; end
            OP_OUT_I:  begin                wr_out = 1'b1; end
            OP_JMP:    begin                jump = 1'b1;   end
            // JNC looks at the carry left by the previous instruction.
            OP_JNC:    begin                jump = !carry_q; end
            default:   begin                wr_carry = 1'b0; end
        endcase
    end

    assign sum = {1'b0, src} + {1'b0, imm};

    // ---------------- Datapath next state ----------------
    always_comb begin
        pc_d     = pc_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        ir_d     = ir_q;
        out_d    = out_q;
        strobe_d = 1'b0;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) ir_d = imem_data;
            end
            ST_EXEC: begin
                if (opcode != OP_HALT) begin
                    pc_d = jump ? sum[DATA_W-1:0] : pc_q + PC_ONE;
                end
                if (wr_a)     a_d     = sum[DATA_W-1:0];
                if (wr_b)     b_d     = sum[DATA_W-1:0];
                if (wr_carry) carry_d = sum[DATA_W];
                if (wr_out) begin
                    out_d    = sum[DATA_W-1:0];
                    strobe_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            ir_q     <= '0;
            out_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            ir_q     <= ir_d;
            out_q    <= out_d;
            strobe_q <= strobe_d;
        end
    end

    assign imem_addr   = pc_q;
    assign out_port    = out_q;
    assign out_strobe  = strobe_q;
    assign dbg_a_o     = a_q;
    assign dbg_b_o     = b_q;
    assign dbg_carry_o = carry_q;
    assign dbg_ir_o    = ir_q;

endmodule

// File: tb/tb_td4x_core.sv
module tb_td4x_core;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DATA_W=4 instance ----------------
  logic [3:0]  addr4, in4, out4, a4, b4;
  logic        req4, ack4, stb4, hlt4, c4;
  logic [7:0]  data4, ir4;
  logic [1:0]  st4;
  logic [7:0]  mem4[16];
  int          wcnt4;

  // ---------------- DATA_W=8 instance ----------------
  logic [7:0]  addr8, in8, out8, a8, b8;
  logic        req8, ack8, stb8, hlt8, c8;
  logic [11:0] data8, ir8;
  logic [1:0]  st8;
  logic [11:0] mem8[256];
  int          wcnt8;

  int   stall_n;
  logic force_ack;

  td4x_core #(.DATA_W(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .imem_addr(addr4), .imem_req(req4), .imem_ack(ack4), .imem_data(data4),
    .in_port(in4), .out_port(out4), .out_strobe(stb4), .halted(hlt4),
    .dbg_state_o(st4), .dbg_a_o(a4), .dbg_b_o(b4), .dbg_carry_o(c4), .dbg_ir_o(ir4)
  );

  td4x_core #(.DATA_W(8)) u_dut8 (
    .clk(clk), .reset(reset),
    .imem_addr(addr8), .imem_req(req8), .imem_ack(ack8), .imem_data(data8),
    .in_port(in8), .out_port(out8), .out_strobe(stb8), .halted(hlt8),
    .dbg_state_o(st8), .dbg_a_o(a8), .dbg_b_o(b8), .dbg_carry_o(c8), .dbg_ir_o(ir8)
  );

  // Program memory model: answers after stall_n wait cycles.
  assign data4 = mem4[addr4];
  assign data8 = mem8[addr8];
  assign ack4  = force_ack | (req4 && (wcnt4 >= stall_n));
  assign ack8  = force_ack | (req8 && (wcnt8 >= stall_n));

  always @(posedge clk) begin
    wcnt4 <= (req4 && !ack4) ? wcnt4 + 1 : 0;
    wcnt8 <= (req8 && !ack8) ? wcnt8 + 1 : 0;
  end

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem4[i] = 8'h80;
    for (int i = 0; i < 256; i++) mem8[i] = 12'h800;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] in_v;
    logic [7:0] p0, p1, p2, p3;
    logic [3:0] ea, eb;
    logic       ec;
    logic [3:0] epc, eout;
    logic       estb, ehlt;
  } vec_t;

  vec_t vecs[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; force_ack = 1'b0; stall_n = 0;
    in4 = 4'h0; in8 = 8'h00;
    clear_mem();

    //            in     p0     p1     p2     p3     A     B     C     PC    OUT   STB   HLT
    vecs[0]  = '{4'h0, 8'h3A, 8'h75, 8'h80, 8'h07, 4'h1, 4'h5, 1'b1, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{4'h0, 8'h31, 8'h72, 8'h80, 8'h53, 4'h1, 4'h5, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[2]  = '{4'h0, 8'h30, 8'h79, 8'h80, 8'h10, 4'h9, 4'h9, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[3]  = '{4'h0, 8'h3C, 8'h70, 8'h80, 8'h40, 4'hC, 4'hC, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[4]  = '{4'h6, 8'h30, 8'h70, 8'h80, 8'h20, 4'h6, 4'h0, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[5]  = '{4'hF, 8'h30, 8'h70, 8'h80, 8'h61, 4'h0, 4'h0, 1'b1, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[6]  = '{4'h0, 8'h30, 8'h73, 8'h80, 8'h90, 4'h0, 4'h3, 1'b0, 4'h4, 4'h3, 1'b1, 1'b0};
    vecs[7]  = '{4'h0, 8'h30, 8'h70, 8'h80, 8'hB7, 4'h0, 4'h0, 1'b0, 4'h4, 4'h7, 1'b1, 1'b0};
    vecs[8]  = '{4'h0, 8'h30, 8'h70, 8'h80, 8'hF9, 4'h0, 4'h0, 1'b0, 4'h9, 4'h0, 1'b0, 1'b0};
    vecs[9]  = '{4'h0, 8'h30, 8'h70, 8'h80, 8'hE9, 4'h0, 4'h0, 1'b0, 4'h9, 4'h0, 1'b0, 1'b0};
    vecs[10] = '{4'h0, 8'h3F, 8'h70, 8'h01, 8'hE9, 4'h0, 4'h0, 1'b0, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[11] = '{4'h0, 8'h3F, 8'h70, 8'h01, 8'h80, 4'h0, 4'h0, 1'b1, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[12] = '{4'h0, 8'h3F, 8'h70, 8'h01, 8'hA5, 4'h0, 4'h0, 1'b1, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[13] = '{4'h0, 8'h3F, 8'h70, 8'h01, 8'hD3, 4'h0, 4'h0, 1'b1, 4'h4, 4'h0, 1'b0, 1'b0};
    vecs[14] = '{4'h0, 8'h3F, 8'h70, 8'h01, 8'hC0, 4'h0, 4'h0, 1'b1, 4'h3, 4'h0, 1'b0, 1'b1};

    // ---- reset / idle with ack held high ----
    force_ack = 1'b1;
    tick(3);
    check("rst_req",    16'(req4), 16'h0);
    check("rst_out",    16'(out4), 16'h0);
    check("rst_strobe", 16'(stb4), 16'h0);
    check("rst_halted", 16'(hlt4), 16'h0);
    reset = 1'b0; force_ack = 1'b0;
    #1;
    check("rel_req",  16'(req4),  16'h1);
    check("rel_addr", 16'(addr4), 16'h0);

    // ---- table: three setup instructions then the instruction under test ----
    for (int i = 0; i < 15; i++) begin
      clear_mem();
      mem4[0] = vecs[i].p0; mem4[1] = vecs[i].p1;
      mem4[2] = vecs[i].p2; mem4[3] = vecs[i].p3;
      in4 = vecs[i].in_v;
      do_reset();
      tick(8);
      check($sformatf("v%0d_a", i),    16'(a4),    16'(vecs[i].ea));
      check($sformatf("v%0d_b", i),    16'(b4),    16'(vecs[i].eb));
      check($sformatf("v%0d_c", i),    16'(c4),    16'(vecs[i].ec));
      check($sformatf("v%0d_pc", i),   16'(addr4), 16'(vecs[i].epc));
      check($sformatf("v%0d_out", i),  16'(out4),  16'(vecs[i].eout));
      check($sformatf("v%0d_stb", i),  16'(stb4),  16'(vecs[i].estb));
      check($sformatf("v%0d_hlt", i),  16'(hlt4),  16'(vecs[i].ehlt));
      check($sformatf("v%0d_req", i),  16'(req4),  vecs[i].ehlt ? 16'h0 : 16'h1);
    end
    in4 = 4'h0;

    // ---- ALU/carry program on both widths ----
    clear_mem();
    mem4[0] = 8'h33;  mem4[1] = 8'h0E;  mem4[2] = 8'hE0;
    mem4[3] = 8'h40;  mem4[4] = 8'h90;  mem4[5] = 8'hC0;
    mem8[0] = 12'h303; mem8[1] = 12'h0FE; mem8[2] = 12'hE00;
    mem8[3] = 12'h400; mem8[4] = 12'h900; mem8[5] = 12'hC00;
    do_reset();
    tick(4);
    check("alu_a",    16'(a4), 16'h1);
    check("alu_c",    16'(c4), 16'h1);
    check("alu8_a",   16'(a8), 16'h01);
    check("alu8_c",   16'(c8), 16'h1);
    tick(2);
    check("alu_jnc_pc",  16'(addr4), 16'h3);
    check("alu_jnc_c",   16'(c4),    16'h0);
    check("alu8_jnc_pc", 16'(addr8), 16'h03);
    tick(4);
    check("alu_out",   16'(out4), 16'h1);
    check("alu_stb",   16'(stb4), 16'h1);
    check("alu8_out",  16'(out8), 16'h01);
    check("alu8_stb",  16'(stb8), 16'h1);
    tick(1);
    check("alu_stb_end",  16'(stb4), 16'h0);
    check("alu8_stb_end", 16'(stb8), 16'h0);
    tick(1);
    check("alu_halted", 16'(hlt4),  16'h1);
    check("alu_h_addr", 16'(addr4), 16'h5);
    check("alu_h_st",   16'(st4),   16'h2);
    check("alu_h_req",  16'(req4),  16'h0);
    check("alu8_halted",16'(hlt8),  16'h1);
    tick(5);
    check("alu_h_stay",  16'(hlt4),  16'h1);
    check("alu_h_addr2", 16'(addr4), 16'h5);
    check("alu_h_a",     16'(a4),    16'h1);
    check("alu_h_b",     16'(b4),    16'h1);
    check("alu_h_stb",   16'(stb4),  16'h0);

    // ---- jump taken loop ----
    clear_mem();
    mem4[0] = 8'h70; mem4[1] = 8'h50; mem4[2] = 8'hE0;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("loop_addr%0d", k), 16'(addr4), 16'(k % 3));
      tick(2);
    end

    // ---- handshake stall: 3 wait cycles per fetch ----
    clear_mem();
    mem4[0] = 8'h33;  mem4[1] = 8'h0E;  mem4[2] = 8'hE0;
    mem4[3] = 8'h40;  mem4[4] = 8'h90;  mem4[5] = 8'hC0;
    stall_n = 3;
    do_reset();
    for (int t = 0; t < 25; t++) begin
      if ((t % 5) < 4) begin
        check($sformatf("stall_req%0d", t),  16'(req4),  16'h1);
        check($sformatf("stall_addr%0d", t), 16'(addr4), 16'(t / 5));
      end else begin
        check($sformatf("stall_exec_req%0d", t), 16'(req4), 16'h0);
      end
      if (t == 10) begin
        check("stall_a", 16'(a4), 16'h1);
        check("stall_c", 16'(c4), 16'h1);
      end
      tick(1);
    end
    check("stall_out",  16'(out4), 16'h1);
    check("stall_stb",  16'(stb4), 16'h1);
    check("stall_b",    16'(b4),   16'h1);
    check("stall_c2",   16'(c4),   16'h0);
    tick(5);
    check("stall_halted", 16'(hlt4),  16'h1);
    check("stall_h_addr", 16'(addr4), 16'h5);
    stall_n = 0;

    // ---- PC wrap and IN ----
    clear_mem();
    mem4[0] = 8'hFF; mem4[15] = 8'h20;
    in4 = 4'hA;
    do_reset();
    tick(2);
    check("wrap_addr15", 16'(addr4), 16'hF);
    mem4[0] = 8'h07;
    tick(2);
    check("wrap_in_a",  16'(a4),    16'hA);
    check("wrap_in_c",  16'(c4),    16'h0);
    check("wrap_addr0", 16'(addr4), 16'h0);
    tick(2);
    check("wrap_add_a", 16'(a4),    16'h1);
    check("wrap_add_c", 16'(c4),    16'h1);
    check("wrap_addr1", 16'(addr4), 16'h1);
    in4 = 4'h0;

    // ---- JNC at last address with carry set falls through to 0 ----
    clear_mem();
    mem4[0] = 8'h3F; mem4[1] = 8'hFE; mem4[14] = 8'h01; mem4[15] = 8'hE5;
    do_reset();
    tick(6);
    check("jnc_last_c",    16'(c4),    16'h1);
    check("jnc_last_a",    16'(a4),    16'h0);
    check("jnc_last_addr", 16'(addr4), 16'hF);
    tick(2);
    check("jnc_fall_addr", 16'(addr4), 16'h0);
    check("jnc_fall_c",    16'(c4),    16'h0);

    // ---- reset during a stalled fetch with a simultaneous ack ----
    clear_mem();
    mem4[0] = 8'h72; mem4[1] = 8'h35; mem4[2] = 8'h94; mem4[3] = 8'h3F;
    stall_n = 3;
    do_reset();
    tick(15);
    check("mid_pre_a",   16'(a4),    16'h5);
    check("mid_pre_b",   16'(b4),    16'h2);
    check("mid_pre_out", 16'(out4),  16'h6);
    check("mid_pre_stb", 16'(stb4),  16'h1);
    check("mid_pre_ir",  16'(ir4),   16'h94);
    tick(2);
    check("mid_wait_req",  16'(req4),  16'h1);
    check("mid_wait_addr", 16'(addr4), 16'h3);
    reset = 1'b1; force_ack = 1'b1;
    tick(1);
    check("mid_req",   16'(req4),  16'h0);
    check("mid_a",     16'(a4),    16'h0);
    check("mid_b",     16'(b4),    16'h0);
    check("mid_c",     16'(c4),    16'h0);
    check("mid_out",   16'(out4),  16'h0);
    check("mid_stb",   16'(stb4),  16'h0);
    check("mid_addr",  16'(addr4), 16'h0);
    check("mid_ir",    16'(ir4),   16'h0);
    check("mid_state", 16'(st4),   16'h0);
    check("mid_hlt",   16'(hlt4),  16'h0);
    reset = 1'b0; force_ack = 1'b0; stall_n = 0;
    tick(1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
